// File: rtl/int_seq.sv
// rtl/int_seq.sv - interrupt/reset vector sequencer for the CPU control unit
//
// Arbitrates reset, NMI, IRQ and BRK at opcode-fetch boundaries and holds the
// control unit in the interrupt sequence until the vector fetch has begun.
//
// Optional feature macro: INT_SYNC_EN
//   defined   : nmi_n / irq_n pass through a 2-flop synchronizer (reset to 1),
//               adding 2 cycles of input latency.
//   undefined : nmi_n / irq_n are used directly.
//
// Ports
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous, active-high reset
//   nmi_n      in   active-low non-maskable interrupt (edge-sensitive)
//   irq_n      in   active-low maskable interrupt (level-sensitive)
//   i_flag     in   interrupt-disable status bit
//   sync       in   single-cycle opcode-fetch boundary pulse
//   brk        in   BRK opcode decoded (qualified by sync)
//   vec_ack    in   control unit has begun the vector low-byte fetch
//   take_int   out  forces the control unit into the interrupt/reset sequence
//   vec_addr   out  vector low-byte address (FFFC/FFFA/FFFE)
//   b_flag     out  B bit to push with status (1 = BRK, 0 = hardware)
//   reset_seq  out  high while servicing the reset vector

module int_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk,
    input  logic        vec_ack,
    output logic        take_int,
    output logic [15:0] vec_addr,
    output logic        b_flag,
    output logic        reset_seq
);

    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        IDLE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        nmi_pend, nmi_pend_d;
    logic        nmi_q;
    logic        take_int_d;
    logic [15:0] vec_addr_d;
    logic        b_flag_d;
    logic        reset_seq_d;

    logic        nmi_lvl;
    logic        irq_lvl;
    logic        nmi_edge;

`ifdef INT_SYNC_EN
    logic [1:0] nmi_sync;
    logic [1:0] irq_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_sync <= 2'b11;
            irq_sync <= 2'b11;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi_n};
            irq_sync <= {irq_sync[0], irq_n};
        end
    end

    assign nmi_lvl = nmi_sync[1];
    assign irq_lvl = irq_sync[1];
`else
    assign nmi_lvl = nmi_n;
    assign irq_lvl = irq_n;
`endif

    // Falling edge of the (possibly synchronized) NMI level; a held-low pin
    // only produces one edge because nmi_q follows the level.
    assign nmi_edge = nmi_q & ~nmi_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_SEQ;
            nmi_pend  <= 1'b0;
            nmi_q     <= 1'b1;
            take_int  <= 1'b1;
            vec_addr  <= VEC_RST;
            b_flag    <= 1'b0;
            reset_seq <= 1'b1;
        end else begin
            state_q   <= state_d;
            nmi_pend  <= nmi_pend_d;
            nmi_q     <= nmi_lvl;
            take_int  <= take_int_d;
            vec_addr  <= vec_addr_d;
            b_flag    <= b_flag_d;
            reset_seq <= reset_seq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nmi_pend_d  = nmi_pend;
        take_int_d  = take_int;
        vec_addr_d  = vec_addr;
        b_flag_d    = b_flag;
        reset_seq_d = reset_seq;

        case (state_q)
            RST_SEQ: begin
                if (vec_ack) begin
                    state_d     = IDLE;
                    take_int_d  = 1'b0;
                    reset_seq_d = 1'b0;
                end
            end

            IDLE: begin
                if (sync) begin
                    if (nmi_pend) begin
                        state_d    = SERVICE;
                        take_int_d = 1'b1;
                        vec_addr_d = VEC_NMI;
                        b_flag_d   = 1'b0;
                    end else if (!irq_lvl && !i_flag) begin
                        state_d    = SERVICE;
                        take_int_d = 1'b1;
                        vec_addr_d = VEC_IRQ;
                        b_flag_d   = 1'b0;
                    end else if (brk) begin
                        state_d    = SERVICE;
                        take_int_d = 1'b1;
                        vec_addr_d = VEC_IRQ;
                        b_flag_d   = 1'b1;
                    end
                end
            end

            SERVICE: begin
                if (vec_ack) begin
                    state_d    = IDLE;
                    take_int_d = 1'b0;
                    b_flag_d   = 1'b0;
                    if (vec_addr == VEC_NMI) begin
                        nmi_pend_d = 1'b0;
                    end
                end else if (nmi_edge || nmi_pend) begin
                    // NMI arriving before the vector fetch hijacks the
                    // IRQ/BRK sequence; b_flag keeps the original cause.
                    vec_addr_d = VEC_NMI;
                end
            end

            default: begin
                state_d = RST_SEQ;
            end
        endcase

        // A new edge wins over the clear so an NMI coincident with vec_ack
        // is still serviced at the next boundary.
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// tb/tb_int_seq.sv - randomized scoreboard bench for int_seq
module tb_int_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b0;
    logic        sync = 1'b0;
    logic        brk = 1'b0;
    logic        vec_ack = 1'b0;
    logic        take_int;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        reset_seq;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [18:0] exp_q[$];

    int_seq dut (
        .clk       (clk),
        .reset     (reset),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .i_flag    (i_flag),
        .sync      (sync),
        .brk       (brk),
        .vec_ack   (vec_ack),
        .take_int  (take_int),
        .vec_addr  (vec_addr),
        .b_flag    (b_flag),
        .reset_seq (reset_seq)
    );

    always #5 clk = ~clk;

    // Reference model: tracks "what is being serviced" and whether an NMI is
    // owed, and predicts the registered outputs after every edge.
    bit          m_in_reset;
    bit          m_busy;
    logic [15:0] m_vec;
    bit          m_b;
    bit          m_owed;
    bit          m_last_nmi;
    bit          m_p1_nmi, m_p2_nmi, m_p1_irq, m_p2_irq;

    always @(posedge clk) begin
        bit nmi_seen, irq_seen, fell;
        cycle++;
        if (reset) begin
            m_in_reset = 1; m_busy = 1; m_vec = 16'hFFFC; m_b = 0;
            m_owed = 0; m_last_nmi = 1;
            m_p1_nmi = 1; m_p2_nmi = 1; m_p1_irq = 1; m_p2_irq = 1;
        end else begin
`ifdef INT_SYNC_EN
            nmi_seen = m_p2_nmi; irq_seen = m_p2_irq;
            m_p2_nmi = m_p1_nmi; m_p1_nmi = nmi_n;
            m_p2_irq = m_p1_irq; m_p1_irq = irq_n;
`else
            nmi_seen = nmi_n; irq_seen = irq_n;
`endif
            fell = m_last_nmi && !nmi_seen;
            if (m_in_reset) begin
                if (vec_ack) begin m_in_reset = 0; m_busy = 0; end
            end else if (!m_busy) begin
                if (sync) begin
                    if (m_owed) begin m_busy = 1; m_vec = 16'hFFFA; m_b = 0; end
                    else if (!irq_seen && !i_flag) begin m_busy = 1; m_vec = 16'hFFFE; m_b = 0; end
                    else if (brk) begin m_busy = 1; m_vec = 16'hFFFE; m_b = 1; end
                end
            end else if (vec_ack) begin
                if (m_vec == 16'hFFFA) m_owed = 0;
                m_busy = 0; m_b = 0;
            end else if (fell || m_owed) begin
                m_vec = 16'hFFFA;
            end
            if (fell) m_owed = 1;
            m_last_nmi = nmi_seen;
        end
        exp_q.push_back({m_busy, m_vec, m_b, m_in_reset});
    end

    // Monitor: outputs are registered, so one expectation per edge.
    always @(negedge clk) begin
        logic [18:0] e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty cycle %0d got no expectation need one", cycle);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (take_int !== e[18]) begin
                errors++;
                $display("FAIL take_int cycle %0d got %0b exp %0b", cycle, take_int, e[18]);
            end
            checks++;
            if (vec_addr !== e[17:2]) begin
                errors++;
                $display("FAIL vec_addr cycle %0d got %h exp %h", cycle, vec_addr, e[17:2]);
            end
            checks++;
            if (b_flag !== e[1]) begin
                errors++;
                $display("FAIL b_flag cycle %0d got %0b exp %0b", cycle, b_flag, e[1]);
            end
            checks++;
            if (reset_seq !== e[0]) begin
                errors++;
                $display("FAIL reset_seq cycle %0d got %0b exp %0b", cycle, reset_seq, e[0]);
            end
        end
    end

    task automatic tick(input logic s, input logic bk, input logic ack);
        sync = s; brk = bk; vec_ack = ack;
        @(posedge clk); #1;
        sync = 0; brk = 0; vec_ack = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0);
    endtask

    initial begin
        // Reset pulse, then vec_ack on the third cycle of the reset sequence.
        tick(0, 0, 0); tick(0, 0, 0);
        reset = 0;
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 1);
        idle(3);

        // IRQ taken, then masked by i_flag.
        irq_n = 0;
        tick(1, 0, 0); idle(2); tick(0, 0, 1);
        i_flag = 1;
        tick(1, 0, 0); idle(2);
        irq_n = 1; i_flag = 0;
        idle(4);

        // BRK alone, then BRK with an unmasked IRQ (IRQ wins, b_flag=0).
        tick(1, 1, 0); tick(0, 0, 0); tick(0, 0, 1);
        irq_n = 0;
        tick(1, 1, 0); tick(0, 0, 1);
        irq_n = 1;
        idle(4);

        // NMI held low across two sync pulses: exactly one FFFA service.
        nmi_n = 0;
        idle(3); tick(1, 0, 0); idle(2); tick(0, 0, 1);
        idle(4); tick(1, 0, 0); idle(8);
        nmi_n = 1;
        idle(4);

        // BRK hijacked by an NMI edge one cycle in.
        tick(1, 1, 0);
        nmi_n = 0;
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 1);
        idle(2);
        tick(1, 0, 0); idle(2);
        nmi_n = 1;
        idle(4);

        // NMI edge coincident with vec_ack stays owed for the next sync.
        irq_n = 0;
        tick(1, 0, 0); idle(2);
        irq_n = 1;
        nmi_n = 0;
        tick(0, 0, 1);
        idle(2); tick(1, 0, 0); idle(2); tick(0, 0, 1);
        nmi_n = 1;
        idle(4);

        // Reset mid-service, with an NMI owed that reset must discard.
        nmi_n = 0; idle(2); nmi_n = 1; idle(1);
        irq_n = 0; i_flag = 0;
        tick(1, 0, 0); idle(2);
        reset = 1;
        tick(1, 1, 1);
        reset = 0;
        irq_n = 1;
        tick(0, 0, 1);
        tick(1, 0, 0); idle(3);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 15) == 0) i_flag = ~i_flag;
            if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
            reset = ($urandom_range(0, 299) == 0);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0);
        end
        reset = 0;
        idle(4);

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
